// File: rtl/riscq_loader_pkg.sv
// Shared command codes, FSM encoding and word geometry for the riscq init loader.
package riscq_loader_pkg;
    localparam logic [7:0] CMD_INST = 8'hA1;
    localparam logic [7:0] CMD_DATA = 8'hA2;
    localparam logic [7:0] CMD_DONE = 8'hA5;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/riscq_word_pack.sv
// Little-endian byte-to-word packer: the first byte lands in bits [7:0], and
// o_word_valid pulses for one cycle after the 4th byte of a word is strobed in.
module riscq_word_pack (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_strobe,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_valid
);
    logic [1:0]  byte_cnt;
    logic [31:0] sreg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt     <= 2'd0;
            sreg         <= 32'd0;
            o_word       <= 32'd0;
            o_word_valid <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            if (i_clear) begin
                byte_cnt <= 2'd0;
                sreg     <= 32'd0;
            end else if (i_strobe) begin
                sreg     <= {i_byte, sreg[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    o_word       <= {i_byte, sreg[31:8]};
                    o_word_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/riscq_loader.sv
// Host loader: parses CMD/ADDR/CNT/payload/CSUM frames from a byte stream and
// drives the inst_rom and data_ram init write ports of riscq_soc.
module riscq_loader
    import riscq_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [ADDR_W-1:0] o_inst_waddr,
    output logic [DATA_W-1:0] o_inst_wdata,
    output logic              o_inst_we,
    output logic              o_inst_init_done,
    output logic [ADDR_W-1:0] o_data_waddr,
    output logic [DATA_W-1:0] o_data_wdata,
    output logic              o_data_we,
    output logic              o_data_init_done,
    output logic              o_busy,
    output logic              o_err,
    output logic [2:0]        o_dbg_state
);
    // Handshake: a byte transfers on any rising edge where i_rx_valid and
    // o_rx_ready are both high; ready stays high from the cycle after reset.
    state_t              state;
    logic                rdy;
    logic [1:0]          hdr_idx;
    logic [7:0]          addr_l, addr_h, cnt_l, sum;
    logic                tgt_data;
    logic [17:0]         bytes_left;
    logic [ADDR_W-1:0]   inst_addr, data_addr;
    logic [DATA_W-1:0]   inst_wdata_q, data_wdata_q;
    logic                err, inst_done, data_done;
    logic [31:0]         pk_word;
    logic                pk_valid;

    logic        acc;
    logic [11:0] hdr_start;
    logic [15:0] hdr_cnt;
    logic        hdr_bad;
    logic        hdr_last;

    assign acc       = i_rx_valid & rdy;
    assign hdr_start = {addr_h[3:0], addr_l};
    assign hdr_cnt   = {i_rx_data, cnt_l};
    assign hdr_bad   = (addr_h[7:4] != 4'd0) ||
                       ((17'(hdr_start) + 17'(hdr_cnt)) > 17'(1 << ADDR_W));
    assign hdr_last  = acc && (state == S_HDR) && (hdr_idx == 2'd3);

    riscq_word_pack u_pack (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_byte       (i_rx_data),
        .i_strobe     (acc && (state == S_PAYLOAD)),
        .i_clear      (hdr_last),
        .o_word       (pk_word),
        .o_word_valid (pk_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            rdy          <= 1'b0;
            hdr_idx      <= 2'd0;
            addr_l       <= 8'd0;
            addr_h       <= 8'd0;
            cnt_l        <= 8'd0;
            sum          <= 8'd0;
            tgt_data     <= 1'b0;
            bytes_left   <= 18'd0;
            inst_addr    <= '0;
            data_addr    <= '0;
            inst_wdata_q <= '0;
            data_wdata_q <= '0;
            err          <= 1'b0;
            inst_done    <= 1'b0;
            data_done    <= 1'b0;
        end else begin
            rdy <= 1'b1;
            // Each write retires here: the address advances past the word just written.
            if (pk_valid) begin
                if (tgt_data) begin
                    data_addr    <= data_addr + 1'b1;
                    data_wdata_q <= pk_word;
                end else begin
                    inst_addr    <= inst_addr + 1'b1;
                    inst_wdata_q <= pk_word;
                end
            end
            if (acc) begin
                case (state)
                    S_IDLE: begin
                        case (i_rx_data)
                            CMD_INST, CMD_DATA: begin
                                tgt_data <= (i_rx_data == CMD_DATA);
                                sum      <= i_rx_data;
                                hdr_idx  <= 2'd0;
                                state    <= S_HDR;
                            end
                            CMD_DONE: begin
                                inst_done <= 1'b1;
                                data_done <= 1'b1;
                                state     <= S_DONE;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                    S_HDR: begin
                        sum     <= sum + i_rx_data;
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0: addr_l <= i_rx_data;
                            2'd1: addr_h <= i_rx_data;
                            2'd2: cnt_l  <= i_rx_data;
                            default: begin
                                if (hdr_bad) begin
                                    err   <= 1'b1;
                                    state <= S_IDLE;
                                end else begin
                                    bytes_left <= 18'(hdr_cnt) * 18'(BYTES_PER_WORD);
                                    if (tgt_data) data_addr <= ADDR_W'(hdr_start);
                                    else          inst_addr <= ADDR_W'(hdr_start);
                                    state <= (hdr_cnt == 16'd0) ? S_CSUM : S_PAYLOAD;
                                end
                            end
                        endcase
                    end
                    S_PAYLOAD: begin
                        sum        <= sum + i_rx_data;
                        bytes_left <= bytes_left - 18'd1;
                        if (bytes_left == 18'd1) state <= S_CSUM;
                    end
                    S_CSUM: begin
                        if (8'(sum + i_rx_data) != 8'h00) err <= 1'b1;
                        state <= S_IDLE;
                    end
                    S_DONE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Strobes are gated by reset so an in-flight write drops in the reset cycle.
    assign o_inst_we        = pk_valid & ~tgt_data & ~i_rst;
    assign o_data_we        = pk_valid &  tgt_data & ~i_rst;
    assign o_inst_wdata     = o_inst_we ? DATA_W'(pk_word) : inst_wdata_q;
    assign o_data_wdata     = o_data_we ? DATA_W'(pk_word) : data_wdata_q;
    assign o_inst_waddr     = inst_addr;
    assign o_data_waddr     = data_addr;
    assign o_rx_ready       = rdy;
    assign o_inst_init_done = inst_done;
    assign o_data_init_done = data_done;
    assign o_err            = err;
    assign o_busy           = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_CSUM);
    assign o_dbg_state      = state;
endmodule

// File: tb/tb_riscq_loader.sv
// Directed bench for riscq_loader: frames are driven byte by byte and the
// write strobes of both init ports are logged and compared with expected lists.
module tb_riscq_loader;
    import riscq_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [11:0] inst_waddr, data_waddr;
    logic [31:0] inst_wdata, data_wdata;
    logic        inst_we, data_we, inst_done, data_done, busy, err;
    logic [2:0]  dbg_state;

    int checks = 0;
    int passed = 0;
    logic [43:0] inst_log[$];
    logic [43:0] data_log[$];
    logic [43:0] exp_q[$];
    logic [31:0] fw[4];

    riscq_loader #(.ADDR_W(12), .DATA_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_rx_ready(rx_ready),
        .o_inst_waddr(inst_waddr), .o_inst_wdata(inst_wdata), .o_inst_we(inst_we),
        .o_inst_init_done(inst_done),
        .o_data_waddr(data_waddr), .o_data_wdata(data_wdata), .o_data_we(data_we),
        .o_data_init_done(data_done),
        .o_busy(busy), .o_err(err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inst_we) inst_log.push_back({inst_waddr, inst_wdata});
        if (data_we) data_log.push_back({data_waddr, data_wdata});
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        inst_log.delete();
        data_log.delete();
    endtask

    // Sends one complete frame using words from fw[]; csum_adj corrupts the checksum.
    task automatic send_frame(input logic [7:0] cmd, input logic [11:0] addr,
                              input logic [15:0] cnt, input logic [7:0] csum_adj);
        logic [7:0]  s;
        logic [31:0] t;
        logic [7:0]  hdr[5];
        hdr[0] = cmd; hdr[1] = addr[7:0]; hdr[2] = {4'd0, addr[11:8]};
        hdr[3] = cnt[7:0]; hdr[4] = cnt[15:8];
        s = 8'd0;
        for (int i = 0; i < 5; i++) begin s = s + hdr[i]; send_byte(hdr[i]); end
        for (int w = 0; w < int'(cnt); w++) begin
            t = fw[w];
            for (int b = 0; b < 4; b++) begin s = s + t[8*b +: 8]; send_byte(t[8*b +: 8]); end
        end
        send_byte(8'(8'h00 - s + csum_adj));
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({rx_ready, inst_we, inst_done, data_we, data_done, busy, err} !== 7'd0)
            $display("FAIL reset_flags got %b exp 0000000", {rx_ready, inst_we, inst_done, data_we, data_done, busy, err});
        else passed++;
        checks++; if ({inst_waddr, inst_wdata, data_waddr, data_wdata} !== 88'd0)
            $display("FAIL reset_ports got %h exp 0", {inst_waddr, inst_wdata, data_waddr, data_wdata});
        else passed++;
        rst = 1'b0;
        checks++; if (rx_ready !== 1'b0) $display("FAIL ready_early got %b exp 0", rx_ready); else passed++;
        @(posedge clk); #1;
        checks++; if (rx_ready !== 1'b1) $display("FAIL ready_rise got %b exp 1", rx_ready); else passed++;
        checks++; if (dbg_state !== S_IDLE) $display("FAIL reset_state got %0d exp 0", dbg_state); else passed++;
    endtask

    task automatic test_inst_load;
        do_reset();
        fw[0] = 32'h00000013; fw[1] = 32'h00100093;
        send_frame(CMD_INST, 12'h000, 16'd2, 8'd0);
        exp_q = '{{12'h000, 32'h00000013}, {12'h001, 32'h00100093}};
        checks++; if (inst_log.size() != exp_q.size())
            $display("FAIL inst_count got %0d exp %0d", inst_log.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < inst_log.size(); i++) begin
            checks++; if (inst_log[i] !== exp_q[i])
                $display("FAIL inst_word%0d got %h exp %h", i, inst_log[i], exp_q[i]); else passed++;
        end
        checks++; if (data_log.size() != 0) $display("FAIL inst_data_idle got %0d writes exp 0", data_log.size()); else passed++;
        checks++; if ({data_waddr, data_wdata} !== 44'd0) $display("FAIL inst_data_held got %h exp 0", {data_waddr, data_wdata}); else passed++;
        checks++; if ({err, busy} !== 2'b00) $display("FAIL inst_err_busy got %b exp 00", {err, busy}); else passed++;
    endtask

    task automatic test_data_load;
        fw[0] = 32'hDEADBEEF; fw[1] = 32'h12345678;
        send_frame(CMD_DATA, 12'h7FE, 16'd2, 8'd0);
        exp_q = '{{12'h7FE, 32'hDEADBEEF}, {12'h7FF, 32'h12345678}};
        checks++; if (data_log.size() != exp_q.size())
            $display("FAIL data_count got %0d exp %0d", data_log.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < data_log.size(); i++) begin
            checks++; if (data_log[i] !== exp_q[i])
                $display("FAIL data_word%0d got %h exp %h", i, data_log[i], exp_q[i]); else passed++;
        end
        checks++; if (inst_log.size() != 2) $display("FAIL data_inst_idle got %0d writes exp 2", inst_log.size()); else passed++;
        checks++; if ({inst_waddr, inst_wdata} !== {12'h002, 32'h00100093})
            $display("FAIL data_inst_held got %h exp 00200100093", {inst_waddr, inst_wdata}); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL data_err got %b exp 0", err); else passed++;
        send_byte(CMD_DONE);
        checks++; if ({inst_done, data_done} !== 2'b11) $display("FAIL data_done_flags got %b exp 11", {inst_done, data_done}); else passed++;
    endtask

    task automatic test_hdr_overflow;
        do_reset();
        send_byte(8'hA2); send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h02); send_byte(8'h00);
        checks++; if ({err, busy} !== 2'b10) $display("FAIL ovf_err_busy got %b exp 10", {err, busy}); else passed++;
        checks++; if (dbg_state !== S_IDLE) $display("FAIL ovf_state got %0d exp 0", dbg_state); else passed++;
        idle(2);
        checks++; if (inst_log.size() + data_log.size() != 0)
            $display("FAIL ovf_writes got %0d exp 0", inst_log.size() + data_log.size()); else passed++;
        fw[0] = 32'hCAFEF00D;
        send_frame(CMD_INST, 12'h020, 16'd1, 8'd0);
        checks++; if (inst_log.size() != 1) $display("FAIL ovf_reload_count got %0d exp 1", inst_log.size());
        else if (inst_log[0] !== {12'h020, 32'hCAFEF00D})
            $display("FAIL ovf_reload got %h exp 020cafef00d", inst_log[0]);
        else passed++;
    endtask

    task automatic test_bad_cmd;
        do_reset();
        send_byte(8'h33);
        checks++; if ({err, busy} !== 2'b10) $display("FAIL badcmd_err_busy got %b exp 10", {err, busy}); else passed++;
    endtask

    task automatic test_bad_csum;
        do_reset();
        fw[0] = 32'h11223344;
        send_frame(CMD_INST, 12'h005, 16'd1, 8'd1);
        checks++; if (inst_log.size() != 1) $display("FAIL csum_count got %0d exp 1", inst_log.size());
        else if (inst_log[0] !== {12'h005, 32'h11223344})
            $display("FAIL csum_word got %h exp 00511223344", inst_log[0]);
        else passed++;
        checks++; if ({err, busy} !== 2'b10) $display("FAIL csum_err_busy got %b exp 10", {err, busy}); else passed++;
    endtask

    task automatic test_gaps;
        logic [7:0] pay[8];
        logic [7:0] s;
        do_reset();
        pay = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
        s = 8'hA2 + 8'h01 + 8'h02;
        send_byte(8'hA2); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 8; i++) begin
            s = s + pay[i];
            send_byte(pay[i]);
            if (i == 1 || i == 5) idle(2);
            if (i == 2) begin
                checks++; if (data_we !== 1'b0) $display("FAIL gap_early_we got %b exp 0", data_we); else passed++;
            end
            if (i == 3) begin
                checks++; if ({data_we, data_waddr, data_wdata} !== {1'b1, 12'h100, 32'hAABBCCDD})
                    $display("FAIL gap_word0 got %h exp 1100aabbccdd", {data_we, data_waddr, data_wdata}); else passed++;
            end
            if (i == 7) begin
                checks++; if ({data_we, data_waddr, data_wdata} !== {1'b1, 12'h101, 32'h01020304})
                    $display("FAIL gap_word1 got %h exp 110101020304", {data_we, data_waddr, data_wdata}); else passed++;
            end
        end
        send_byte(8'(8'h00 - s));
        checks++; if (data_log.size() != 2) $display("FAIL gap_count got %0d exp 2", data_log.size()); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL gap_err got %b exp 0", err); else passed++;
    endtask

    task automatic test_reset_mid;
        do_reset();
        send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        do_reset();
        fw[0] = 32'h55AA33CC;
        send_frame(CMD_INST, 12'h010, 16'd1, 8'd0);
        checks++; if (inst_log.size() != 1) $display("FAIL rstmid_count got %0d exp 1", inst_log.size());
        else if (inst_log[0] !== {12'h010, 32'h55AA33CC})
            $display("FAIL rstmid_word got %h exp 01055aa33cc", inst_log[0]);
        else passed++;
        send_byte(8'hA1); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        checks++; if (inst_we !== 1'b1) $display("FAIL rstmid_we_pre got %b exp 1", inst_we); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (inst_we !== 1'b0) $display("FAIL rstmid_we_drop got %b exp 0", inst_we); else passed++;
        do_reset();
        checks++; if ({busy, err, inst_done} !== 3'b000) $display("FAIL rstmid_flags got %b exp 000", {busy, err, inst_done}); else passed++;
    endtask

    task automatic test_done;
        do_reset();
        checks++; if ({inst_done, data_done} !== 2'b00) $display("FAIL done_pre got %b exp 00", {inst_done, data_done}); else passed++;
        send_byte(CMD_DONE);
        checks++; if ({inst_done, data_done, busy} !== 3'b110) $display("FAIL done_flags got %b exp 110", {inst_done, data_done, busy}); else passed++;
        checks++; if (dbg_state !== S_DONE) $display("FAIL done_state got %0d exp 4", dbg_state); else passed++;
        fw[0] = 32'h44332211;
        send_frame(CMD_INST, 12'h000, 16'd1, 8'd0);
        idle(2);
        checks++; if (inst_log.size() + data_log.size() != 0)
            $display("FAIL done_writes got %0d exp 0", inst_log.size() + data_log.size()); else passed++;
        checks++; if ({inst_done, data_done, rx_ready, err} !== 4'b1110)
            $display("FAIL done_sticky got %b exp 1110", {inst_done, data_done, rx_ready, err}); else passed++;
    endtask

    initial begin
        test_reset();
        test_inst_load();
        test_data_load();
        test_hdr_overflow();
        test_bad_cmd();
        test_bad_csum();
        test_gaps();
        test_reset_mid();
        test_done();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/riscq_loader.md
Name: riscq_loader

Overview:
- Host-side loader that fills the SoC program and data memories before the core runs.
- Accepts a framed byte stream over a valid/ready handshake from a host bridge (UART/JTAG-to-byte).
- Drives the inst_rom and data_ram initialisation write ports of riscq_soc.
- Raises the init_done flags when the host sends the DONE command.

Parameters:
- ADDR_W, 12, word-address width of both init ports.
- DATA_W, 32, word width; fixed at 4 bytes per word.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_rx_data  in  8  stream byte
- i_rx_valid  in  1  byte valid
- o_rx_ready  out  1  loader accepts byte; a byte transfers when i_rx_valid & o_rx_ready
- o_inst_waddr  out  ADDR_W  inst_rom init word address
- o_inst_wdata  out  32  inst_rom init data
- o_inst_we  out  1  inst_rom init write strobe, single cycle
- o_inst_init_done  out  1  inst_rom init complete, sticky
- o_data_waddr  out  ADDR_W  data_ram init word address
- o_data_wdata  out  32  data_ram init data
- o_data_we  out  1  data_ram init write strobe, single cycle
- o_data_init_done  out  1  data_ram init complete, sticky
- o_busy  out  1  frame in progress (state not IDLE/DONE)
- o_err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0. o_rx_ready rises on the first cycle after i_rst deasserts, then stays 1 (throughput is 1 byte/cycle, no backpressure).
- Frame layout: CMD, ADDR_L, ADDR_H, CNT_L, CNT_H, then CNT×4 payload bytes (little-endian per word), then CSUM.
- CMD codes: 0xA1 = inst load, 0xA2 = data load, 0xA5 = done. DONE has no further bytes.
- CSUM: the 8-bit sum of every frame byte from CMD through CSUM must equal 0x00.
- States: IDLE -> HDR (4-byte counter) -> PAYLOAD -> CSUM -> IDLE; DONE is terminal.
- IDLE, 0xA1/0xA2: latch the target, go to HDR.
- IDLE, 0xA5: set both init_done the next cycle, go to DONE.
- IDLE, any other CMD: set o_err, stay in IDLE.
- HDR errors: ADDR_H[7:4]≠0, or start+CNT>4096 → o_err=1 and return to IDLE after CNT_H; no writes occur. CNT=0 skips PAYLOAD and goes straight to CSUM.
- PAYLOAD packing: bytes go into a 32-bit shift register, first byte → bits[7:0].
- PAYLOAD writes: the 4th byte of a word is accepted at cycle N. At N+1 the target we=1 with waddr=current address and wdata=packed word. The address then increments. Only the selected target's we pulses; the other port's outputs are held.
- Write ordering: word k is written to start+k. The last word never wraps past 4095, because the header check guarantees it.
- CSUM mismatch: o_err=1 and return to IDLE. Writes already issued are not undone; the host must reload.
- DONE: all further bytes are accepted and discarded. No writes occur. init_done flags stay 1 until i_rst.
- o_err is sticky until i_rst. Loading continues normally after an error.
- i_rst mid-frame: state→IDLE, we strobes drop the same cycle, partial word discarded, flags cleared.
- i_rx_valid low: all state holds. A word can straddle idle gaps.

Decomposition:
- Package riscq_loader_pkg holds: CMD_INST=0xA1, CMD_DATA=0xA2, CMD_DONE=0xA5; the state encoding (IDLE, HDR, PAYLOAD, CSUM, DONE); BYTES_PER_WORD=4.
- One natural sub-module: riscq_word_pack, the byte-to-word packer.
  - Inputs: byte, strobe, clear.
  - Outputs: word, word_valid pulse.
  - Contents: 2-bit byte counter plus 32-bit shift register.

Test Plan:
- Inst load: A1 00 00 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM → o_inst_we pulses twice: addr 0x000 data 0x00000013, then addr 0x001 data 0x00100093. o_err=0, data port idle.
- Data load at 0x7FE with CNT=2, words 0xDEADBEEF and 0x12345678 → o_data_we pulses at 0x7FE and 0x7FF with matching data. Then A5 → both init_done=1 one cycle later.
- Header overflow: A2 with addr 0xFFF, CNT=2 → no we pulses, o_err=1, loader back in IDLE. A following valid A1 frame loads correctly.
- Bad CSUM (valid frame, last byte +1) → the word is written, o_err=1 after the CSUM byte, state IDLE.
- Stall and gaps: valid toggled 1-0-0-1 inside payload → packed words identical to the gap-free case; each we fires one cycle after the 4th byte.
- Reset mid-payload after 2 bytes, then a full A1 frame at addr 0x010 → no stray write, first write at 0x010 with correct data. Bytes after A5 produce no writes.
